// File: rtl/atm_fwd_core.sv
// ATM cell forwarding core: round-robin receive arbiter, UNI HEC check,
// VPI table lookup with NNI header rewrite, multicast into per-port FIFOs.
module atm_fwd_core #(
    parameter int NumRx     = 4,
    parameter int NumTx     = 4,
    parameter int FifoDepth = 4,
    parameter int CntWidth  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NumRx-1:0]        rx_valid,
    output logic [NumRx-1:0]        rx_ready,
    input  logic [NumRx*424-1:0]    rx_cell,
    output logic [NumTx-1:0]        tx_valid,
    input  logic [NumTx-1:0]        tx_ready,
    output logic [NumTx*424-1:0]    tx_cell,
    input  logic                    cfg_we,
    input  logic                    cfg_re,
    input  logic [7:0]              cfg_addr,
    input  logic [NumTx+11:0]       cfg_wdata,
    output logic [NumTx+11:0]       cfg_rdata,
    input  logic                    cnt_clr,
    output logic [CntWidth-1:0]     hec_err_cnt,
    output logic [CntWidth-1:0]     drop_cnt
);

    localparam int PW = (NumRx > 1) ? $clog2(NumRx) : 1;
    localparam int AW = $clog2(FifoDepth);
    localparam int QW = AW + 1;
    localparam int TW = NumTx + 12;
    localparam int DW = $clog2(NumTx + 1);
    localparam int SW = ((CntWidth > DW) ? CntWidth : DW) + 1;
    localparam logic [CntWidth-1:0] CntMax = '1;

    typedef enum logic [1:0] {IDLE, CHECK, ENQ} state_e;

    state_e              state_q;
    logic [PW-1:0]       ptr_q;
    logic [423:0]        cell_q;
    logic [NumTx-1:0]    mask_q;
    logic [TW-1:0]       tbl_q [256];
    logic [TW-1:0]       rdata_q;
    logic [CntWidth-1:0] hec_cnt_q, hec_cnt_d;
    logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic [423:0]        mem_q [NumTx][FifoDepth];
    logic [AW-1:0]       wp_q [NumTx];
    logic [AW-1:0]       rp_q [NumTx];
    logic [QW-1:0]       cnt_q [NumTx];

    function automatic logic [7:0] hec8(input logic [31:0] h);
        logic [7:0] c;
        c = '0;
        for (int b = 31; b >= 0; b--) begin
            if (c[7] ^ h[b]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c ^ 8'h55;
    endfunction

    function automatic logic [CntWidth-1:0] sat_add(
        input logic [CntWidth-1:0] c,
        input logic [DW-1:0]       n
    );
        logic [SW-1:0] s;
        s = SW'(c) + SW'(n);
        return (s > SW'(CntMax)) ? CntMax : s[CntWidth-1:0];
    endfunction

    // Round-robin search starting at ptr_q
    logic [NumRx-1:0] grant;
    logic [PW-1:0]    gidx;
    logic [PW-1:0]    ridx;
    logic             found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        ridx  = '0;
        found = 1'b0;
        for (int k = 0; k < NumRx; k++) begin
            ridx = PW'((int'(ptr_q) + k) % NumRx);
            if (!found && rx_valid[ridx]) begin
                found       = 1'b1;
                grant[ridx] = 1'b1;
                gidx        = ridx;
            end
        end
    end

    assign rx_ready = (state_q == IDLE && !rst) ? grant : '0;

    logic [31:0]   hdr;
    logic [31:0]   nhdr;
    logic [TW-1:0] ent;
    logic          hec_ok;

    assign hdr    = cell_q[423:392];
    assign hec_ok = (cell_q[391:384] == hec8(hdr));
    assign ent    = tbl_q[hdr[27:20]];
    assign nhdr   = {ent[11:0], hdr[19:0]};

    logic [NumTx-1:0] push, pop, full;
    logic [DW-1:0]    ndrop;

    always_comb begin
        push  = '0;
        pop   = '0;
        full  = '0;
        ndrop = '0;
        for (int j = 0; j < NumTx; j++) begin
            full[j] = (cnt_q[j] == QW'(FifoDepth));
            push[j] = (state_q == ENQ) && mask_q[j] && !full[j];
            pop[j]  = (cnt_q[j] != '0) && tx_ready[j];
            if ((state_q == ENQ) && mask_q[j] && full[j])
                ndrop = ndrop + DW'(1);
        end
    end

    always_comb begin
        tx_valid = '0;
        tx_cell  = '0;
        for (int j = 0; j < NumTx; j++) begin
            tx_valid[j] = (cnt_q[j] != '0);
            if (cnt_q[j] != '0)
                tx_cell[j*424 +: 424] = mem_q[j][rp_q[j]];
        end
    end

    // Clear wins over any increment landing in the same cycle
    always_comb begin
        hec_cnt_d  = sat_add(hec_cnt_q,
                             DW'(state_q == CHECK && !hec_ok));
        drop_cnt_d = sat_add(drop_cnt_q, ndrop);
        if (cnt_clr) begin
            hec_cnt_d  = '0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cell_q     <= '0;
            mask_q     <= '0;
            hec_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            hec_cnt_q  <= hec_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            case (state_q)
                IDLE: begin
                    if (|rx_ready) begin
                        cell_q  <= rx_cell[int'(gidx)*424 +: 424];
                        ptr_q   <= (gidx == PW'(NumRx - 1)) ?
                                   '0 : gidx + PW'(1);
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!hec_ok) begin
                        state_q <= IDLE;
                    end else begin
                        cell_q  <= {nhdr, hec8(nhdr), cell_q[383:0]};
                        mask_q  <= ent[TW-1:12];
                        state_q <= ENQ;
                    end
                end
                ENQ:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NumTx; j++) begin
                wp_q[j]  <= '0;
                rp_q[j]  <= '0;
                cnt_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NumTx; j++) begin
                if (push[j]) begin
                    mem_q[j][wp_q[j]] <= cell_q;
                    wp_q[j]           <= wp_q[j] + AW'(1);
                end
                if (pop[j])
                    rp_q[j] <= rp_q[j] + AW'(1);
                case ({push[j], pop[j]})
                    2'b10:   cnt_q[j] <= cnt_q[j] + QW'(1);
                    2'b01:   cnt_q[j] <= cnt_q[j] - QW'(1);
                    default: cnt_q[j] <= cnt_q[j];
                endcase
            end
        end
    end

    // Table lookups in CHECK see the pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++)
                tbl_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (cfg_we)
                tbl_q[cfg_addr] <= cfg_wdata;
            if (cfg_re)
                rdata_q <= tbl_q[cfg_addr];
        end
    end

    assign cfg_rdata   = rdata_q;
    assign hec_err_cnt = hec_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_atm_fwd_core.sv
// Bench for atm_fwd_core: directed scenarios plus random traffic,
// every cycle compared against a cell-level reference model.
module tb_atm_fwd_core;

    localparam int NR = 4;
    localparam int NT = 4;
    localparam int FD = 4;
    localparam int CW = 2;
    localparam int TW = NT + 12;
    localparam int CMAX = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      rx_valid;
    logic [NR-1:0]      rx_ready;
    logic [NR*424-1:0]  rx_cell;
    logic [NT-1:0]      tx_valid;
    logic [NT-1:0]      tx_ready;
    logic [NT*424-1:0]  tx_cell;
    logic               cfg_we;
    logic               cfg_re;
    logic [7:0]         cfg_addr;
    logic [TW-1:0]      cfg_wdata;
    logic [TW-1:0]      cfg_rdata;
    logic               cnt_clr;
    logic [CW-1:0]      hec_err_cnt;
    logic [CW-1:0]      drop_cnt;

    atm_fwd_core #(
        .NumRx(NR), .NumTx(NT), .FifoDepth(FD), .CntWidth(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_cell(rx_cell),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_cell(tx_cell),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .cnt_clr(cnt_clr), .hec_err_cnt(hec_err_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: a cell in flight with an age, queues per output
    int            phase;
    logic [423:0]  mcell;
    logic [NT-1:0] mmask;
    int            ptr;
    logic [423:0]  mq [NT][$];
    logic [TW-1:0] mtbl [256];
    int            mh, md;
    logic [TW-1:0] mrd;
    logic [NR-1:0] obs_ready;
    int            deliv1;

    task automatic chk(input string tag, input logic [423:0] got,
                       input logic [423:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_hec(input logic [31:0] h);
        logic [7:0] crc;
        crc = 8'h00;
        for (int b = 0; b < 4; b++) begin
            crc = crc ^ h[31 - 8*b -: 8];
            for (int i = 0; i < 8; i++)
                crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
        end
        return crc ^ 8'h55;
    endfunction

    function automatic logic [423:0] mk_cell(input logic [31:0] h,
                                             input logic good);
        logic [383:0] pl;
        logic [7:0]   hb;
        for (int i = 0; i < 12; i++) pl[i*32 +: 32] = $urandom;
        hb = good ? ref_hec(h) : (ref_hec(h) ^ 8'h01);
        return {h, hb, pl};
    endfunction

    function automatic int exp_grant();
        int idx;
        if (rst || phase != 0) return -1;
        for (int k = 0; k < NR; k++) begin
            idx = (ptr + k) % NR;
            if (rx_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int osz [NT];
        int nd;
        int hinc;
        int g;
        logic [31:0]   h, nh;
        logic [TW-1:0] e;
        if (rst) begin
            phase = 0; ptr = 0; mh = 0; md = 0; mrd = '0;
            for (int j = 0; j < NT; j++) mq[j].delete();
            for (int i = 0; i < 256; i++) mtbl[i] = '0;
            return;
        end
        nd = 0; hinc = 0;
        for (int j = 0; j < NT; j++) osz[j] = mq[j].size();
        for (int j = 0; j < NT; j++)
            if (osz[j] > 0 && tx_ready[j]) void'(mq[j].pop_front());
        g = exp_grant();
        if (phase == 2) begin
            for (int j = 0; j < NT; j++)
                if (mmask[j]) begin
                    if (osz[j] < FD) mq[j].push_back(mcell);
                    else nd++;
                end
            phase = 0;
        end else if (phase == 1) begin
            h = mcell[423:392];
            if (mcell[391:384] != ref_hec(h)) begin
                hinc = 1; phase = 0;
            end else begin
                e = mtbl[h[27:20]];
                nh = {e[11:0], h[19:0]};
                mcell = {nh, ref_hec(nh), mcell[383:0]};
                mmask = e[TW-1:12];
                phase = 2;
            end
        end else if (g >= 0) begin
            mcell = rx_cell[g*424 +: 424];
            ptr = (g + 1) % NR;
            phase = 1;
        end
        if (cfg_re) mrd = mtbl[cfg_addr];
        if (cfg_we) mtbl[cfg_addr] = cfg_wdata;
        if (cnt_clr) begin
            mh = 0; md = 0;
        end else begin
            mh = (mh + hinc > CMAX) ? CMAX : mh + hinc;
            md = (md + nd > CMAX) ? CMAX : md + nd;
        end
    endtask

    task automatic check_outputs();
        logic [NT-1:0] ev;
        for (int j = 0; j < NT; j++) ev[j] = (mq[j].size() > 0);
        chk("tx_valid", 424'(tx_valid), 424'(ev));
        for (int j = 0; j < NT; j++)
            if (ev[j])
                chk($sformatf("tx_cell%0d", j),
                    tx_cell[j*424 +: 424], mq[j][0]);
        chk("hec_err_cnt", 424'(hec_err_cnt), 424'(mh));
        chk("drop_cnt", 424'(drop_cnt), 424'(md));
        chk("cfg_rdata", 424'(cfg_rdata), 424'(mrd));
        if (tx_valid[1] && tx_ready[1]) deliv1++;
    endtask

    task automatic cycle();
        int g;
        logic [NR-1:0] er;
        #1;
        g = exp_grant();
        er = (g >= 0) ? (NR'(1) << g) : '0;
        obs_ready = rx_ready;
        chk("rx_ready", 424'(rx_ready), 424'(er));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic tbl_wr(input logic [7:0] a, input logic [TW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic send(input int p, input logic [423:0] c);
        rx_valid = '0;
        rx_valid[p] = 1'b1;
        rx_cell[p*424 +: 424] = c;
        cycle();
        rx_valid = '0;
        run(2);
    endtask

    function automatic logic [31:0] hdr_vpi(input logic [7:0] v);
        return {4'h0, v, 20'h00000};
    endfunction

    int grants [$];

    initial begin
        rst = 1'b1; rx_valid = '0; rx_cell = '0; tx_ready = '0;
        cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cnt_clr = 1'b0; deliv1 = 0;
        phase = 0; ptr = 0; mh = 0; md = 0; mrd = '0;
        mcell = '0; mmask = '0;
        for (int i = 0; i < 256; i++) mtbl[i] = '0;
        @(negedge clk);
        run(2);
        for (int j = 0; j < NT; j++)
            chk("rst_tx_cell", tx_cell[j*424 +: 424], '0);
        chk("rst_rx_ready", 424'(rx_ready), '0);
        rst = 1'b0;

        // Unicast: all-zero header through VPI 0 to tx 1
        tbl_wr(8'h00, {4'b0010, 12'h0AB});
        send(0, mk_cell(32'h0, 1'b1));
        chk("uni_valid", 424'(tx_valid), 424'(4'b0010));
        chk("uni_hdr", 424'(tx_cell[424+392 +: 32]), 424'(32'h0AB00000));
        chk("uni_hec", 424'(tx_cell[424+384 +: 8]),
            424'(ref_hec(32'h0AB00000)));
        tx_ready = '1;
        run(1);

        // Bad HEC discarded, next good cell forwarded
        send(0, {32'h0, 8'h54, 384'h0});
        chk("bad_hec_cnt", 424'(hec_err_cnt), 424'(1));
        chk("bad_no_valid", 424'(tx_valid), '0);
        send(0, mk_cell(32'h0, 1'b1));
        run(1);

        // Round-robin from a fresh pointer
        rst = 1'b1; run(1); rst = 1'b0;
        tbl_wr(8'h20, {4'b0001, 12'h120});
        tx_ready = '1;
        rx_valid = '1;
        for (int c = 0; c < 15; c++) begin
            for (int p = 0; p < NR; p++)
                rx_cell[p*424 +: 424] = mk_cell(hdr_vpi(8'h20), 1'b1);
            cycle();
            for (int p = 0; p < NR; p++)
                if (obs_ready[p]) grants.push_back(p);
        end
        rx_valid = '0;
        run(3);
        chk("rr_count", 424'(grants.size()), 424'(5));
        for (int i = 0; i < grants.size() && i < 5; i++)
            chk("rr_grant", 424'(grants[i]), 424'(i % NR));

        // Overflow into stalled tx 0
        cnt_clr = 1'b1; run(1); cnt_clr = 1'b0;
        tbl_wr(8'h30, {4'b0011, 12'h300});
        tx_ready = 4'b0010;
        deliv1 = 0;
        for (int i = 0; i < 6; i++)
            send(i % NR, mk_cell(hdr_vpi(8'h30), 1'b1));
        run(2);
        chk("ovf_drop", 424'(drop_cnt), 424'(2));
        chk("ovf_tx1", 424'(deliv1), 424'(6));
        chk("ovf_tx0_valid", 424'(tx_valid[0]), 424'(1));
        tx_ready = '1;
        run(6);

        // Table readback
        tbl_wr(8'h7F, 16'hA5C3);
        cfg_re = 1'b1; cfg_addr = 8'h7F;
        cycle();
        cfg_re = 1'b0;
        chk("cfg_rd", 424'(cfg_rdata), 424'(16'hA5C3));

        // Clear beats a same-cycle increment, then saturate
        send(1, mk_cell(hdr_vpi(8'h7F), 1'b0));
        cnt_clr = 1'b1;
        send(2, mk_cell(hdr_vpi(8'h7F), 1'b0));
        cnt_clr = 1'b0;
        chk("clr_hec", 424'(hec_err_cnt), '0);
        for (int i = 0; i < 5; i++)
            send(i % NR, mk_cell(hdr_vpi(8'h01), 1'b0));
        chk("sat_hec", 424'(hec_err_cnt), 424'(CMAX));

        // Reset while a cell sits in CHECK
        tbl_wr(8'h40, {4'b1111, 12'h440});
        tx_ready = '0;
        send(3, mk_cell(hdr_vpi(8'h40), 1'b1));
        rx_valid = 4'b0100;
        rx_cell[2*424 +: 424] = mk_cell(hdr_vpi(8'h40), 1'b1);
        cycle();
        rx_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_valid", 424'(tx_valid), '0);
        chk("rst_mid_hec", 424'(hec_err_cnt), '0);
        run(4);
        chk("rst_mid_after", 424'(tx_valid), '0);

        // Random traffic
        for (int it = 0; it < 800; it++) begin
            rx_valid = NR'($urandom);
            for (int p = 0; p < NR; p++)
                rx_cell[p*424 +: 424] = mk_cell(
                    {4'($urandom), 5'b0, 3'($urandom), 20'($urandom)},
                    $urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 8'($urandom_range(0, 8));
            cfg_wdata = TW'($urandom);
            cfg_re    = ($urandom_range(0, 3) == 0);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            tx_ready  = NT'($urandom);
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rx_valid = '0; cfg_we = 1'b0; cfg_re = 1'b0;
        cnt_clr = 1'b0; rst = 1'b0; tx_ready = '1;
        run(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/atm_fwd_core.md
# atm_fwd_core

Parametrised ATM cell forwarding core for the Utopia switch. It arbitrates round-robin among NumRx receive ports and checks each cell's UNI HEC. It then looks up a 256-entry VPI table, rewrites the header to NNI format with a regenerated HEC, and multicasts the cell into per-output show-ahead FIFOs. Unlike the unbuffered quad squat, outputs are decoupled by FifoDepth-deep buffers, overflow is dropped and counted, and the table can be read back.

## Interface
- NumRx, 4: receive ports, 1..16.
- NumTx, 4: transmit ports, 1..16.
- FifoDepth, 4: cells per output FIFO, power of 2, ≥2.
- CntWidth, 16: width of the statistics counters.

- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  NumRx  cell offered on port i.
- rx_ready  out  NumRx  cell accepted; transfer when valid&ready.
- rx_cell  in  NumRx*424  53-byte cell per port; byte 0 in bits [423:416] of each slice.
- tx_valid  out  NumTx  FIFO j non-empty.
- tx_ready  in  NumTx  sink pops FIFO j head.
- tx_cell  out  NumTx*424  head of FIFO j.
- cfg_we  in  1  table write strobe.
- cfg_re  in  1  table read strobe.
- cfg_addr  in  8  table index (UNI VPI).
- cfg_wdata  in  NumTx+12  {forward mask, new 12-bit NNI VPI}.
- cfg_rdata  out  NumTx+12  read data, registered.
- cnt_clr  in  1  clears both counters.
- hec_err_cnt  out  CntWidth  cells discarded for bad HEC.
- drop_cnt  out  CntWidth  cell copies refused by a full FIFO.

## Operation
- Header = bytes 0..3 (32 bits H). In UNI format, VPI = H[27:20]. Byte 4 is the HEC.
- HEC = CRC-8 over bytes 0..3, MSB first, polynomial x^8+x^2+x+1 (0x07), initial value 0x00, result XORed with 0x55.
- FSM states: IDLE, CHECK, ENQ. Reset state is IDLE.
- IDLE:
  - The grant goes to the first i with rx_valid[i], searching ptr, ptr+1, … modulo NumRx.
  - rx_ready[i] = (state==IDLE) & grant[i]. It is combinational from rx_valid; at most one bit is high.
  - On the handshake: capture the cell, set ptr <= (i+1) mod NumRx, and go to CHECK. With no valid, stay in IDLE and hold ptr.
- CHECK:
  - If byte 4 ≠ HEC(bytes 0..3): hec_err_cnt increments and the FSM returns to IDLE.
  - Otherwise read table[VPI] into mask and nvpi. Rewrite H[31:20] = nvpi (the GFC is overwritten) and set byte 4 = HEC of the new bytes 0..3. Go to ENQ.
- ENQ:
  - For each j with mask[j]: if count_j < FifoDepth, push the cell. Otherwise drop that copy.
  - drop_cnt increments by the number of dropped copies in the cycle.
  - mask = 0: the cell is discarded silently, with no count.
  - Always go to IDLE.
- Output FIFOs:
  - Show-ahead: tx_valid[j] = !empty, and tx_cell holds the head.
  - Pop on tx_valid&tx_ready.
  - Fullness is judged on the registered count. A same-cycle pop does not free space for an ENQ push.
  - A push and a pop in the same cycle leave the count unchanged.
- Table:
  - cfg_we writes at the posedge.
  - A CHECK lookup of an address being written in the same cycle returns the old value.
  - cfg_re returns table[cfg_addr] on cfg_rdata the next cycle; otherwise cfg_rdata holds its value.
  - Table reads and writes are independent of the FSM.
- Counters:
  - Saturate at all-ones.
  - cnt_clr takes priority over any same-cycle increment: the result is 0.

## Timing
- Reset values:
  - state IDLE, ptr 0, all FIFOs empty.
  - tx_valid 0, rx_ready 0, tx_cell 0, cfg_rdata 0.
  - Counters 0, all table entries 0.
- Reset mid-cell: the cell in flight is lost and the FIFOs are flushed. No counter increments.
- Latency: accepted at cycle T, CHECK at T+1, ENQ at T+2, tx_valid at T+3 (FIFO previously empty).
- Throughput: at most one cell per 3 cycles; a bad-HEC cell occupies 2 cycles.
- tx_cell and tx_valid are stable while tx_valid & !tx_ready.

## Test plan
- Unicast path:
  - Stimulus: table[0] = {4'b0010, 12'h0AB}; rx port 0 sends header 00 00 00 00 with HEC 0x55.
  - Response: only tx 1 asserts valid at T+3. Header bytes are 0A B0 00 00, and the HEC matches the CRC reference model.
- Bad HEC:
  - Stimulus: the same cell with HEC 0x54.
  - Response: no tx_valid; hec_err_cnt = 1. A following good cell is forwarded.
- Round-robin fairness:
  - Stimulus: all 4 rx ports valid continuously, each cell to tx 0, with tx_ready held high.
  - Response: grants in order 0,1,2,3,0; no port starved.
- Overflow:
  - Stimulus: FifoDepth = 4; mask 4'b0011 with tx_ready[0] = 0 and tx_ready[1] = 1; send 6 cells.
  - Response: tx 0 holds 4 cells, drop_cnt = 2, and tx 1 delivers all 6.
- Table read and counters:
  - Stimulus: write table[8'h7F]; read it back; hold cnt_clr while a bad cell arrives; then saturate with CntWidth = 2.
  - Response: cfg_rdata = the written value one cycle after cfg_re. hec_err_cnt = 0 after the clear, and stops at 3.
- Reset mid-cell:
  - Stimulus: assert rst during CHECK.
  - Response: all outputs return to reset values the next cycle, and no tx_valid follows.
